// File: rtl/instr_issuer_if.sv
// ----------------------------------------------------------------------------
// instr_issuer_if
// CPU-side instruction handshake bundle between the issuer (master) and the
// CPU top (slave).
//   cpu_in    [15:0]  instruction word presented to the CPU
//   cpu_load          instruction-register load enable
//   cpu_s             CPU start
//   cpu_w             CPU wait/idle flag (1 = idle, ready for work)
//   cpu_out   [15:0]  CPU datapath output
//   cpu_nvz   [2:0]   {N,V,Z} status flags from the CPU
// ----------------------------------------------------------------------------
interface instr_issuer_if;
    logic [15:0] cpu_in;
    logic        cpu_load;
    logic        cpu_s;
    logic        cpu_w;
    logic [15:0] cpu_out;
    logic [2:0]  cpu_nvz;

    modport master (
        output cpu_in, cpu_load, cpu_s,
        input  cpu_w, cpu_out, cpu_nvz
    );

    modport slave (
        input  cpu_in, cpu_load, cpu_s,
        output cpu_w, cpu_out, cpu_nvz
    );
endinterface

// File: rtl/instr_issuer.sv
// ----------------------------------------------------------------------------
// instr_issuer
// Host-side sequencer for the CPU instruction interface. A small program RAM
// is filled by the host; on go the words are issued in order using the
// load / start / wait handshake, and the CPU result and flags are captured
// after every completed instruction.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_prog_we      program RAM write strobe (ignored while busy)
//   i_prog_addr    program RAM write address
//   i_prog_data    instruction word to write
//   i_go           start issuing (only looked at while idle)
//   i_count        number of instructions to issue (values above DEPTH clamp)
//   cpu            CPU handshake bundle (master side)
//   o_busy         sequence in progress
//   o_done         one-cycle pulse at the end of a sequence
//   o_err          sticky timeout flag, cleared by the next accepted go
//   o_pc           index being issued / number of instructions completed
//   o_last_out     cpu_out captured at each completion
//   o_last_nvz     cpu_nvz captured at each completion
//
// State  | meaning
// -------+------------------------------------------------------------------
// S_IDLE | waiting for go
// S_READY| sequence accepted, waiting for the CPU to report idle (cpu_w=1)
// S_LOAD | cpu_load high for one cycle with the current word on cpu_in
// S_START| cpu_s high until the CPU drops cpu_w (timed)
// S_WAIT | waiting for cpu_w to return high (timed)
// S_CAPT | capture result/flags, advance pc, finish or load the next word
// ----------------------------------------------------------------------------
module instr_issuer #(
    parameter int AW      = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 63
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_prog_we,
    input  logic [AW-1:0]         i_prog_addr,
    input  logic [15:0]           i_prog_data,
    input  logic                  i_go,
    input  logic [AW:0]           i_count,
    instr_issuer_if.master        cpu,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [AW:0]           o_pc,
    output logic [15:0]           o_last_out,
    output logic [2:0]            o_last_nvz
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPT
    } state_t;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    // Down-counter reload: terminal count 0 is reached on the TIMEOUT-th
    // cycle spent in the timed state.
    localparam logic [TW-1:0] TMO_INIT = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

    state_t         r_state;
    logic [AW:0]    r_pc;
    logic [AW:0]    r_count;
    logic [TW-1:0]  r_tmo;
    logic [15:0]    r_cpu_in;
    logic           r_cpu_load;
    logic           r_cpu_s;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [15:0]    r_last_out;
    logic [2:0]     r_last_nvz;
    logic [15:0]    r_mem [DEPTH];

    logic [AW:0]    w_count_clamp;
    logic [AW:0]    w_pc_inc;
    logic [15:0]    w_rd_cur;
    logic [15:0]    w_rd_next;

    assign w_count_clamp = (i_count > DEPTH_C) ? DEPTH_C : i_count;
    assign w_pc_inc      = r_pc + (AW + 1)'(1);
    assign w_rd_cur      = r_mem[r_pc[AW-1:0]];
    // Only used when another word follows, so the index never wraps in use.
    assign w_rd_next     = r_mem[w_pc_inc[AW-1:0]];

    // Program RAM is deliberately not reset; writes are locked out while a
    // sequence runs so the program cannot change underneath the issuer.
    always_ff @(posedge clk) begin
        if (i_prog_we && !r_busy) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_count    <= '0;
            r_tmo      <= '0;
            r_cpu_in   <= '0;
            r_cpu_load <= 1'b0;
            r_cpu_s    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_last_out <= '0;
            r_last_nvz <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        r_err <= 1'b0;
                        if (w_count_clamp == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_count <= w_count_clamp;
                            r_pc    <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_READY;
                        end
                    end
                end
                S_READY: begin
                    if (cpu.cpu_w) begin
                        r_cpu_in   <= w_rd_cur;
                        r_cpu_load <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cpu_load <= 1'b0;
                    r_cpu_s    <= 1'b1;
                    r_tmo      <= TMO_INIT;
                    r_state    <= S_START;
                end
                S_START: begin
                    if (!cpu.cpu_w) begin
                        r_cpu_s <= 1'b0;
                        r_tmo   <= TMO_INIT;
                        r_state <= S_WAIT;
                    end else if (r_tmo == '0) begin
                        r_err   <= 1'b1;
                        r_cpu_s <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo - TW'(1);
                    end
                end
                S_WAIT: begin
                    if (cpu.cpu_w) begin
                        r_state <= S_CAPT;
                    end else if (r_tmo == '0) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo - TW'(1);
                    end
                end
                S_CAPT: begin
                    r_last_out <= cpu.cpu_out;
                    r_last_nvz <= cpu.cpu_nvz;
                    r_pc       <= w_pc_inc;
                    if (w_pc_inc == r_count) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        // Back-to-back issue: the CPU just reported idle, so
                        // the ready check is skipped.
                        r_cpu_in   <= w_rd_next;
                        r_cpu_load <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu.cpu_in   = r_cpu_in;
    assign cpu.cpu_load = r_cpu_load;
    assign cpu.cpu_s    = r_cpu_s;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_pc         = r_pc;
    assign o_last_out   = r_last_out;
    assign o_last_nvz   = r_last_nvz;

endmodule

// File: tb/tb_instr_issuer.sv
// ----------------------------------------------------------------------------
// tb_instr_issuer
// Scoreboard bench for instr_issuer. A behavioural CPU answers the handshake
// with random latencies and executes a tiny MOV/ADD/CMP instruction set. At
// each launch the expected loads and the expected end-of-sequence record are
// pushed into queues from a program copy and an ISA-level register model; a
// separate monitor pops and compares whenever cpu_load or done is seen.
// ----------------------------------------------------------------------------
module tb_instr_issuer;
    localparam int AW      = 4;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 63;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           prog_we = 1'b0;
    logic [AW-1:0]  prog_addr = '0;
    logic [15:0]    prog_data = '0;
    logic           go = 1'b0;
    logic [AW:0]    count = '0;
    logic           busy, done, err;
    logic [AW:0]    pc;
    logic [15:0]    last_out;
    logic [2:0]     last_nvz;

    instr_issuer_if bus();

    instr_issuer #(.AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr),
        .i_prog_data (prog_data),
        .i_go        (go),
        .i_count     (count),
        .cpu         (bus),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_pc        (pc),
        .o_last_out  (last_out),
        .o_last_nvz  (last_nvz)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_pc;
        int          pc;
        bit          err;
        logic [15:0] lo;
        logic [2:0]  ln;
        int          slen;
    } done_t;

    done_t       exp_done[$];
    logic [15:0] exp_load[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [15:0]      mem_copy [DEPTH];
    logic [7:0][15:0] rregs = '0;
    logic [15:0]      rcout = '0;
    logic [2:0]       rcnvz = '0;
    logic [15:0]      rlast_out = '0;
    logic [2:0]       rlast_nvz = '0;

    int hang_kind = 0;
    int hang_idx  = 0;
    int launch_id = 0;
    int s_run = 0;
    int last_s_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected by scoreboard", name);
    endtask

    // ISA: 110_10 Rn imm8 = MOV Rn,#sx(imm8)
    //      101_00 Rn Rd 00 Rm = ADD Rd,Rn,Rm (writes out and flags)
    //      101_01 Rn 000 00 Rm = CMP Rn,Rm  (flags only)
    function automatic void isa_exec(input logic [15:0] ir, input logic [7:0][15:0] ri,
                                     input logic [15:0] oi, input logic [2:0] fi,
                                     output logic [7:0][15:0] ro, output logic [15:0] oo,
                                     output logic [2:0] fo);
        logic [15:0] a, b, r;
        ro = ri;
        oo = oi;
        fo = fi;
        a  = ri[ir[10:8]];
        b  = ri[ir[2:0]];
        case (ir[15:11])
            5'b11010: ro[ir[10:8]] = {{8{ir[7]}}, ir[7:0]};
            5'b10100: begin
                r = a + b;
                ro[ir[7:5]] = r;
                oo = r;
                fo = {r[15], (a[15] == b[15]) && (r[15] != a[15]), r == 16'h0};
            end
            5'b10101: begin
                r = a - b;
                fo = {r[15], (a[15] != b[15]) && (r[15] != a[15]), r == 16'h0};
            end
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] v;
        case ($urandom_range(0, 2))
            0:       v = {5'b11010, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
            1:       v = {5'b10100, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))};
            default: v = {5'b10101, 3'($urandom_range(0, 7)), 3'b000, 2'b00, 3'($urandom_range(0, 7))};
        endcase
        return v;
    endfunction

    task automatic wr(input int a, input logic [15:0] dv);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a[AW-1:0];
        prog_data = dv;
        mem_copy[a] = dv;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic run_seq(input int cnt, input int hk, input int hidx, input bit inj,
                           input bit wr_go, input int wa, input logic [15:0] wd);
        int eff;
        int t;
        done_t d;
        logic [7:0][15:0] nr;
        logic [15:0] no;
        logic [2:0] nf;
        if (wr_go) mem_copy[wa] = wd;
        eff = (cnt > DEPTH) ? DEPTH : cnt;
        d.chk_pc = (eff != 0);
        d.pc     = eff;
        d.err    = 1'b0;
        d.slen   = -1;
        for (int i = 0; i < eff; i++) begin
            exp_load.push_back(mem_copy[i]);
            if (hk != 0 && i == hidx) begin
                d.pc   = i;
                d.err  = 1'b1;
                d.slen = (hk == 1) ? TIMEOUT : -1;
                break;
            end
            isa_exec(mem_copy[i], rregs, rcout, rcnvz, nr, no, nf);
            rregs = nr;
            rcout = no;
            rcnvz = nf;
            rlast_out = rcout;
            rlast_nvz = rcnvz;
        end
        d.lo = rlast_out;
        d.ln = rlast_nvz;
        exp_done.push_back(d);
        hang_kind = hk;
        hang_idx  = hidx;
        launch_id++;
        @(negedge clk);
        go    = 1'b1;
        count = cnt[AW:0];
        if (wr_go) begin
            prog_we   = 1'b1;
            prog_addr = wa[AW-1:0];
            prog_data = wd;
        end
        @(negedge clk);
        go      = 1'b0;
        prog_we = 1'b0;
        if (inj) begin
            repeat (2) @(negedge clk);
            go        = 1'b1;
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = ~mem_copy[0];
            @(negedge clk);
            go      = 1'b0;
            prog_we = 1'b0;
        end
        t = 0;
        while (exp_done.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_done.size() != 0) begin
            fail_evt("seq_timeout");
            exp_done.delete();
        end
        repeat (3) @(negedge clk);
        check("loads_consumed", exp_load.size(), 0);
        exp_load.delete();
    endtask

    // Behavioural CPU: idle with w=1; after s, drops w, later raises it with
    // the executed result. hang_kind 1 never drops w, 2 never raises it.
    initial begin
        int d1, d2, k, my_launch, c_idx;
        logic [15:0] c_ir;
        logic [7:0][15:0] cregs, nr;
        logic [15:0] no;
        logic [2:0] nf;
        bus.cpu_w   = 1'b1;
        bus.cpu_out = '0;
        bus.cpu_nvz = '0;
        cregs = '0;
        c_ir = '0;
        c_idx = 0;
        my_launch = 0;
        forever begin
            @(posedge clk);
            #1;
            if (my_launch != launch_id) begin
                my_launch = launch_id;
                c_idx = 0;
            end
            if (bus.cpu_load) c_ir = bus.cpu_in;
            if (bus.cpu_s && bus.cpu_w) begin
                if (hang_kind == 1 && c_idx == hang_idx) begin
                    k = 0;
                    while (bus.cpu_s && k < 300) begin
                        @(posedge clk);
                        #1;
                        k++;
                    end
                end else begin
                    d1 = $urandom_range(0, 3);
                    if (d1 != 0) begin
                        repeat (d1) @(posedge clk);
                        #1;
                    end
                    bus.cpu_w = 1'b0;
                    if (hang_kind == 2 && c_idx == hang_idx) begin
                        k = 0;
                        while (busy && k < 300) begin
                            @(posedge clk);
                            #1;
                            k++;
                        end
                    end else begin
                        d2 = $urandom_range(1, 4);
                        repeat (d2) @(posedge clk);
                        #1;
                        isa_exec(c_ir, cregs, bus.cpu_out, bus.cpu_nvz, nr, no, nf);
                        cregs = nr;
                        bus.cpu_out = no;
                        bus.cpu_nvz = nf;
                    end
                    bus.cpu_w = 1'b1;
                    c_idx++;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a load or done.
    initial begin
        done_t d;
        logic [15:0] w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_run = 0;
            end else begin
                if (bus.cpu_s) s_run++;
                else if (s_run != 0) begin
                    last_s_len = s_run;
                    s_run = 0;
                end
                if (bus.cpu_load) begin
                    if (exp_load.size() == 0) fail_evt("unexpected_load");
                    else begin
                        w = exp_load.pop_front();
                        check("cpu_in", bus.cpu_in, w);
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) fail_evt("unexpected_done");
                    else begin
                        d = exp_done.pop_front();
                        if (d.chk_pc) check("pc", pc, d.pc);
                        check("err", err, d.err);
                        check("last_out", last_out, d.lo);
                        check("last_nvz", last_nvz, d.ln);
                        check("busy_at_done", busy, 0);
                        if (d.slen >= 0) check("s_high_cycles", last_s_len, d.slen);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_in"}, bus.cpu_in, 0);
        check({tag, "_cpu_load"}, bus.cpu_load, 0);
        check({tag, "_cpu_s"}, bus.cpu_s, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_last_out"}, last_out, 0);
        check({tag, "_last_nvz"}, last_nvz, 0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single MOV R1,#5
        wr(0, 16'hD105);
        run_seq(1, 0, 0, 0, 0, 0, '0);

        // MOV R0,#7; MOV R1,#2; ADD R2,R1,R0 -> 9, flags clear
        wr(0, 16'hD007);
        wr(1, 16'hD102);
        wr(2, 16'hA140);
        run_seq(3, 0, 0, 0, 0, 0, '0);
        check("add_result", last_out, 16'd9);
        check("add_flags", last_nvz, 3'b000);

        // MOV R0,#3; MOV R1,#3; CMP R0,R1 -> Z set
        wr(0, 16'hD003);
        wr(1, 16'hD103);
        wr(2, 16'hA801);
        run_seq(3, 0, 0, 0, 0, 0, '0);
        check("cmp_flags", last_nvz, 3'b001);
        check("cmp_pc", pc, 3);

        // Reset while cpu_s is held in S_START
        exp_load.push_back(mem_copy[0]);
        hang_kind = 1;
        hang_idx  = 0;
        launch_id++;
        @(negedge clk);
        go    = 1'b1;
        count = 5'd1;
        @(negedge clk);
        go = 1'b0;
        t = 0;
        while (!bus.cpu_s && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("s_before_reset", bus.cpu_s, 1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_load.delete();
        exp_done.delete();
        rlast_out = '0;
        rlast_nvz = '0;
        @(negedge clk);
        rst_n = 1'b1;
        hang_kind = 0;
        repeat (2) @(negedge clk);
        // RAM survives reset
        run_seq(3, 0, 0, 0, 0, 0, '0);

        // Timeout in S_START, then count=0 go clears err
        run_seq(2, 1, 0, 0, 0, 0, '0);
        check("err_sticky", err, 1);
        run_seq(0, 0, 0, 0, 0, 0, '0);
        check("err_cleared", err, 0);

        // Timeout in S_WAIT at index 1, then a clean run
        run_seq(3, 2, 1, 0, 0, 0, '0);
        run_seq(3, 0, 0, 0, 0, 0, '0);

        // go / prog_we while busy are ignored
        run_seq(3, 0, 0, 1, 0, 0, '0);
        run_seq(3, 0, 0, 0, 0, 0, '0);

        // go together with a write: written word is issued
        run_seq(2, 0, 0, 0, 1, 0, 16'hD1AA);

        // Full random program, count above DEPTH clamps
        for (int i = 0; i < DEPTH; i++) wr(i, rand_instr());
        run_seq(20, 0, 0, 0, 0, 0, '0);

        for (int it = 0; it < 25; it++) begin
            int cnt, hk, hi, eff;
            bit inj;
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < DEPTH; i++) wr(i, rand_instr());
            end
            cnt = $urandom_range(0, 20);
            eff = (cnt > DEPTH) ? DEPTH : cnt;
            hk = 0;
            hi = 0;
            if (eff != 0 && $urandom_range(0, 5) == 0) begin
                hk = $urandom_range(1, 2);
                hi = $urandom_range(0, eff - 1);
            end
            inj = (eff != 0) && ($urandom_range(0, 3) == 0);
            run_seq(cnt, hk, hi, inj, 0, 0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
